// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state type and default timing constants for the stopwatch controller
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } sw_state_t;

  localparam int DEF_TICK_DIV = 5_000_000;
  localparam int DEF_DEB_CYC  = 500_000;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - active-low button: 2-flop sync, debounce, registered press pulse
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronizers reset to released so a button held at reset release still yields one press.
  // The press pulse is registered on the same edge the new level is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM, 0.1 s prescaler and lap/clear strobes
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DEB_CYC  = DEF_DEB_CYC
) (
  input  logic       clock_50M,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic       count_en,
  output logic       clear,
  output logic       lap_load,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          ss_press;
  logic          lr_press;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [PW-1:0] presc;
  logic          presc_last;

  btn_conditioner #(.DEB_CYC(DEB_CYC)) u_ss (
    .clk   (clock_50M),
    .rst   (reset),
    .btn_n (start_stop),
    .press (ss_press)
  );

  btn_conditioner #(.DEB_CYC(DEB_CYC)) u_lr (
    .clk   (clock_50M),
    .rst   (reset),
    .btn_n (lap_reset),
    .press (lr_press)
  );

  // start_stop has priority: a simultaneous lap_reset press is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_press) state_d = ST_RUN;
      ST_RUN:  if (ss_press) state_d = ST_STOP;
      ST_STOP: begin
        if (ss_press)      state_d = ST_RUN;
        else if (lr_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign presc_last = (presc == PW'(TICK_DIV - 1));

  // Prescaler holds through STOP so a resume keeps the partial tick.
  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_RUN:  presc <= presc_last ? '0 : presc + PW'(1);
        ST_STOP: presc <= presc;
        default: presc <= '0;
      endcase
    end
  end

  assign count_en = (state_q == ST_RUN) && presc_last;
  assign lap_load = (state_q == ST_RUN) && lr_press && !ss_press;
  assign clear    = (state_q == ST_IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl (TICK_DIV=4, DEB_CYC=3)
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss  = 1'b1;
  logic       lr  = 1'b1;
  logic       count_en;
  logic       clear;
  logic       lap_load;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int ce_n;
  int ll_n;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYC(3)) dut (
    .clock_50M  (clk),
    .reset      (rst),
    .start_stop (ss),
    .lap_reset  (lr),
    .count_en   (count_en),
    .clear      (clear),
    .lap_load   (lap_load),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, output int ce, output int ll);
    ce = 0;
    ll = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (count_en === 1'b1) ce++;
      if (lap_load === 1'b1) ll++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(3);
    check("rst_state", state, S_IDLE);
    check("rst_clear", clear, 1);
    check("rst_count_en", count_en, 0);
    check("rst_lap_load", lap_load, 0);
    rst = 1'b0;
    tick(2);
    check("post_rst_state", state, S_IDLE);

    // start: RUN six cycles after the raw edge, count_en on every 4th RUN cycle
    ss = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("start_latency_idle", state, S_IDLE);
    end
    tick(1);
    check("start_run", state, S_RUN);
    check("start_clear_low", clear, 0);
    check("start_ce0", count_en, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check("run_ce_period", count_en, (k % 4 == 3) ? 1 : 0);
    end
    ss = 1'b1;
    tick(8);
    check("hold_release_run", state, S_RUN);

    // stop while prescaler=2, prescaler frozen through STOP
    tick(1);
    ss = 1'b0;
    tick(5);
    check("stop_pre", state, S_RUN);
    tick(1);
    check("stop_state", state, S_STOP);
    check("stop_ce", count_en, 0);
    ss = 1'b1;
    run_count(30, ce_n, ll_n);
    check("stop_no_ce", ce_n, 0);
    check("stop_hold", state, S_STOP);

    // resume: partial tick kept, count_en in first RUN cycle
    ss = 1'b0;
    tick(5);
    check("resume_pre", state, S_STOP);
    tick(1);
    check("resume_run", state, S_RUN);
    check("resume_ce_first", count_en, 1);
    tick(1);
    check("resume_ce_next", count_en, 0);
    ss = 1'b1;
    tick(9);

    // lap press in RUN
    lr = 1'b0;
    tick(4);
    check("lap_pre", lap_load, 0);
    tick(1);
    check("lap_pulse", lap_load, 1);
    check("lap_state", state, S_RUN);
    tick(1);
    check("lap_single", lap_load, 0);
    check("lap_state2", state, S_RUN);
    check("lap_ce_same_phase", count_en, 1);
    lr = 1'b1;
    tick(8);

    // two-cycle bounce glitch: rejected
    lr = 1'b0;
    tick(2);
    lr = 1'b1;
    run_count(10, ce_n, ll_n);
    check("glitch_no_lap", ll_n, 0);
    check("glitch_state", state, S_RUN);

    // both pressed together: start_stop wins
    ss = 1'b0;
    lr = 1'b0;
    tick(5);
    check("both_no_lap", lap_load, 0);
    check("both_pre", state, S_RUN);
    tick(1);
    check("both_stop", state, S_STOP);
    check("both_no_lap2", lap_load, 0);
    check("both_no_clear", clear, 0);
    ss = 1'b1;
    lr = 1'b1;
    tick(10);

    // lap_reset in STOP -> IDLE, then ignored in IDLE
    lr = 1'b0;
    tick(6);
    check("stop_lr_idle", state, S_IDLE);
    check("stop_lr_clear", clear, 1);
    lr = 1'b1;
    tick(10);
    lr = 1'b0;
    run_count(10, ce_n, ll_n);
    check("idle_lr_nolap", ll_n, 0);
    check("idle_lr_state", state, S_IDLE);
    check("idle_lr_clear", clear, 1);
    lr = 1'b1;
    tick(10);

    // async reset mid-RUN, button held through reset release
    ss = 1'b0;
    tick(6);
    check("rerun", state, S_RUN);
    ss = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    check("async_rst_state", state, S_IDLE);
    check("async_rst_ce", count_en, 0);
    check("async_rst_clear", clear, 1);
    ss = 1'b0;
    run_count(3, ce_n, ll_n);
    check("rst_hold_no_ce", ce_n, 0);
    rst = 1'b0;
    tick(5);
    check("held_btn_pre", state, S_IDLE);
    tick(1);
    check("held_btn_run", state, S_RUN);
    ss = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000, meaning clock_50M cycles per 0.1 s count tick.
REQ-002 SHALL have parameter DEB_CYC, default 500_000, meaning cycles a synchronized button level must be stable before it is accepted (10 ms).
REQ-003 SHALL have port clock_50M, input, 1, the single 50 MHz clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start_stop, input, 1, asynchronous active-low push-button, 0 = pressed.
REQ-006 SHALL have port lap_reset, input, 1, asynchronous active-low push-button, 0 = pressed.
REQ-007 SHALL have port count_en, output, 1, one-cycle pulse telling the BCD timer datapath to advance 0.1 s.
REQ-008 SHALL have port clear, output, 1, level telling the datapath to hold timer and lap digits at zero.
REQ-009 SHALL have port lap_load, output, 1, one-cycle pulse telling the datapath to copy the timer digits into the lap digits.
REQ-010 SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer, then a debouncer that updates its accepted level only after the synchronized level differs from it for DEB_CYC consecutive cycles.
REQ-012 SHALL produce a registered one-cycle press pulse on each 1->0 transition of an accepted level. Holding a button produces exactly one pulse. Release produces none.
REQ-013 SHALL implement states IDLE=2'b00, RUN=2'b01, STOP=2'b10. Encoding 2'b11 SHALL recover to IDLE on the next edge.
REQ-014 In IDLE, a start_stop press SHALL move the FSM to RUN. A lap_reset press SHALL be ignored.
REQ-015 In RUN, a start_stop press SHALL move the FSM to STOP. A lap_reset press SHALL assert lap_load for one cycle and the FSM SHALL remain in RUN.
REQ-016 In STOP, a start_stop press SHALL move the FSM to RUN. A lap_reset press SHALL move the FSM to IDLE.
REQ-017 If both press pulses occur in the same cycle, start_stop SHALL win and the lap_reset pulse SHALL be discarded, with no lap_load and no clear.
REQ-018 Prescaler (width ceil(log2(TICK_DIV))):
  - SHALL be held at 0 in IDLE.
  - SHALL count 0..TICK_DIV-1 and wrap in RUN.
  - SHALL freeze its value in STOP, so a resume keeps the partial tick.
REQ-019 count_en SHALL be 1 for exactly the one cycle in RUN where the prescaler equals TICK_DIV-1. First count_en after IDLE->RUN SHALL occur TICK_DIV cycles after entering RUN.
REQ-020 clear SHALL be 1 exactly while state==IDLE.
REQ-021 The state change caused by a button press SHALL occur DEB_CYC+3 cycles after the raw input edge (2 sync + debounce + pulse register).
REQ-022 count_en and lap_load MAY both be 1 in the same cycle. The datapath SHALL capture the pre-increment value, and this requirement is documented at the interface.

Reset
REQ-023 While reset=1 and on release, outputs SHALL be: state=IDLE, clear=1, count_en=0, lap_load=0. Prescaler, debounce counters and edge registers SHALL be 0. Accepted button levels SHALL be 1 (released).
REQ-024 Reset asserted mid-RUN or mid-debounce SHALL take effect immediately, with no pulse emitted on release.
REQ-025 A button already held low at reset release SHALL generate one press after DEB_CYC+3 cycles.

Structure
REQ-026 A shared package stopwatch_pkg SHALL hold the state typedef sw_state_t and default TICK_DIV/DEB_CYC constants.
REQ-027 Button conditioning SHALL be one sub-module, btn_conditioner (sync, debounce, press pulse), instantiated twice.

Verification (TICK_DIV=4, DEB_CYC=3)
REQ-028 Reset, then start_stop low 20 cycles -> RUN at raw edge+6 cycles, clear falls with it. count_en pulses every 4 cycles, first 4 cycles after RUN entry.
REQ-029 In RUN, start_stop press at prescaler=2, wait 30 cycles, press again -> STOP with no count_en during STOP. First count_en 1 cycle after re-entering RUN.
REQ-030 In RUN, lap_reset press -> single lap_load pulse, state stays RUN. A 2-cycle bounce glitch on lap_reset -> no pulse.
REQ-031 In STOP, lap_reset press -> IDLE and clear=1. In IDLE, lap_reset press -> no change.
REQ-032 Both buttons pressed on the same cycle in RUN -> STOP with no lap_load. Asynchronous reset asserted mid-RUN -> IDLE immediately and no count_en.
